branch_history_table: RTL

BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

---
 rtl/bp_pkg.sv | 15 +
 rtl/sat_counter_next.sv | 21 ++
 rtl/branch_history_table.sv | 110 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared 2-bit branch counter encodings and helpers
package bp_pkg;

    typedef enum logic [1:0] {
        CNT_NN = 2'b00,
        CNT_NT = 2'b01,
        CNT_TN = 2'b10,
        CNT_TT = 2'b11
    } cnt_t;

    function automatic logic cnt_taken(input cnt_t cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/sat_counter_next.sv
// rtl/sat_counter_next.sv - saturating next-state for a 2-bit branch counter
module sat_counter_next
    import bp_pkg::*;
(
    input  cnt_t cur_cnt,
    input  logic taken,
    output cnt_t next_cnt
);

    always_comb begin
        next_cnt = cur_cnt;
        unique case (cur_cnt)
            CNT_NN: next_cnt = taken ? CNT_NT : CNT_NN;
            CNT_NT: next_cnt = taken ? CNT_TN : CNT_NN;
            CNT_TN: next_cnt = taken ? CNT_TT : CNT_NT;
            CNT_TT: next_cnt = taken ? CNT_TT : CNT_TN;
            default: next_cnt = CNT_NN;
        endcase
    end

endmodule

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit counter branch predictor; BHT_GSHARE_EN adds gshare history indexing
module branch_history_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32
) (
    input  logic                        clk_in,
    input  logic                        nrst_in,
    input  logic                        pred_valid_in,
    input  logic [PC_W-1:0]             pred_pc_in,
    output logic                        pred_valid_out,
    output logic                        pred_taken_out,
    output logic [1:0]                  pred_conf_out,
    input  logic                        upd_valid_in,
    input  logic [PC_W-1:0]             upd_pc_in,
    input  logic                        upd_taken_in
`ifdef BHT_GSHARE_EN
    ,
    output logic [$clog2(ENTRIES)-1:0]  pred_hist_out,
    input  logic [$clog2(ENTRIES)-1:0]  upd_hist_in
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    if ((ENTRIES < 4) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
        $error("branch_history_table: ENTRIES must be a power of two and at least 4");
    end

    logic [IDX_W-1:0] pred_pc_idx;
    logic [IDX_W-1:0] upd_pc_idx;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;

    // Instruction words are 4-byte aligned, so the two LSBs carry no information.
    assign pred_pc_idx = pred_pc_in[IDX_W+1:2];
    assign upd_pc_idx  = upd_pc_in[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_in[PC_W-1:IDX_W+2], pred_pc_in[1:0],
                              upd_pc_in[PC_W-1:IDX_W+2], upd_pc_in[1:0]};

    cnt_t cnt_q [ENTRIES];
    cnt_t upd_cur;
    cnt_t upd_next;
    cnt_t pred_conf_q;

    assign upd_cur = cnt_q[upd_idx];

    sat_counter_next u_sat_counter_next (
        .cur_cnt  (upd_cur),
        .taken    (upd_taken_in),
        .next_cnt (upd_next)
    );

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_NN;
            end
        end else if (upd_valid_in) begin
            cnt_q[upd_idx] <= upd_next;
        end
    end

    // Reads the pre-edge array, so a same-index update is never bypassed.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            pred_valid_out <= 1'b0;
            pred_conf_q    <= CNT_NN;
        end else begin
            pred_valid_out <= pred_valid_in;
            if (pred_valid_in) begin
                pred_conf_q <= cnt_q[pred_idx];
            end
        end
    end

    assign pred_conf_out  = pred_conf_q;
    assign pred_taken_out = cnt_taken(pred_conf_q);

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    logic [IDX_W-1:0] pred_hist_q;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            ghr         <= '0;
            pred_hist_q <= '0;
        end else begin
            if (upd_valid_in) begin
                ghr <= {ghr[IDX_W-2:0], upd_taken_in};
            end
            if (pred_valid_in) begin
                pred_hist_q <= ghr;
            end
        end
    end

    // The update carries back the history seen at lookup so both hit the same entry.
    assign pred_idx      = pred_pc_idx ^ ghr;
    assign upd_idx       = upd_pc_idx ^ upd_hist_in;
    assign pred_hist_out = pred_hist_q;
`else
    assign pred_idx = pred_pc_idx;
    assign upd_idx  = upd_pc_idx;
`endif

endmodule
